// File: rtl/operand_issue.sv
// Issue stage for the pipelined ALU: register file, hazard scoreboard,
// operand launch and fixed-latency result writeback.
module operand_issue #(
  parameter int unsigned n    = 32,
  parameter int unsigned LAT  = 1,
  parameter int unsigned NREG = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         instr_valid,
  output logic         instr_ready,
  input  logic [11:0]  instr,
  input  logic         ld_en,
  input  logic [2:0]   ld_addr,
  input  logic [n-1:0] ld_data,
  output logic [n-1:0] R2,
  output logic [n-1:0] R3,
  output logic [2:0]   ALUOp,
  input  logic [n-1:0] alu_result,
  input  logic         alu_overflow,
  input  logic         alu_zero,
  input  logic         alu_carry,
  output logic         overflow,
  output logic         zero,
  output logic         carry,
  output logic         busy,
  input  logic [2:0]   dbg_addr,
  output logic [n-1:0] dbg_data
);

  localparam int unsigned AW    = 3;
  localparam int unsigned OPW   = 3;
  localparam int unsigned DEPTH = LAT + 1;

  logic [OPW-1:0]  f_op;
  logic [AW-1:0]   f_rd, f_rs, f_rt;

  logic [n-1:0]    rf_q [NREG];
  logic [n-1:0]    rf_d [NREG];
  logic [NREG-1:0] pend_q, pend_d;
  logic [DEPTH-1:0] tok_v_q, tok_v_d;
  logic [AW-1:0]   tok_rd_q [DEPTH];
  logic [AW-1:0]   tok_rd_d [DEPTH];
  logic [n-1:0]    r2_q, r2_d, r3_q, r3_d;
  logic [OPW-1:0]  op_q, op_d;
  logic            ovf_q, ovf_d, zero_q, zero_d, carry_q, carry_d;
  logic            busy_q, busy_d;
  logic            accept;
  logic            wb_en;
  logic [AW-1:0]   wb_rd;

  assign f_op = instr[11:9];
  assign f_rd = instr[8:6];
  assign f_rs = instr[5:3];
  assign f_rt = instr[2:0];

  // Stall on host load or any pending write to a source or destination register.
  assign instr_ready = !ld_en && !pend_q[f_rs] && !pend_q[f_rt] && !pend_q[f_rd];
  assign accept      = instr_valid && instr_ready;

  // The token in the last slot is the one whose result is on alu_result now.
  assign wb_en = tok_v_q[LAT];
  assign wb_rd = tok_rd_q[LAT];

  always_comb begin
    rf_d     = rf_q;
    pend_d   = pend_q;
    tok_v_d  = '0;
    tok_rd_d = tok_rd_q;
    r2_d     = r2_q;
    r3_d     = r3_q;
    op_d     = op_q;
    ovf_d    = ovf_q;
    zero_d   = zero_q;
    carry_d  = carry_q;

    // Writeback is applied after the host load so it wins on a shared address.
    if (ld_en) rf_d[ld_addr] = ld_data;
    if (wb_en) begin
      rf_d[wb_rd]   = alu_result;
      pend_d[wb_rd] = 1'b0;
      ovf_d         = alu_overflow;
      zero_d        = alu_zero;
      carry_d       = alu_carry;
    end

    tok_v_d[0]  = accept;
    tok_rd_d[0] = f_rd;
    for (int i = 1; i < int'(DEPTH); i++) begin
      tok_v_d[i]  = tok_v_q[i-1];
      tok_rd_d[i] = tok_rd_q[i-1];
    end

    if (accept) begin
      r2_d         = rf_q[f_rs];
      r3_d         = rf_q[f_rt];
      op_d         = f_op;
      pend_d[f_rd] = 1'b1;
    end

    busy_d = |tok_v_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NREG); i++) rf_q[i] <= '0;
      for (int i = 0; i < int'(DEPTH); i++) tok_rd_q[i] <= '0;
      pend_q  <= '0;
      tok_v_q <= '0;
      r2_q    <= '0;
      r3_q    <= '0;
      op_q    <= '0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
      carry_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      rf_q     <= rf_d;
      tok_rd_q <= tok_rd_d;
      pend_q   <= pend_d;
      tok_v_q  <= tok_v_d;
      r2_q     <= r2_d;
      r3_q     <= r3_d;
      op_q     <= op_d;
      ovf_q    <= ovf_d;
      zero_q   <= zero_d;
      carry_q  <= carry_d;
      busy_q   <= busy_d;
    end
  end

  assign R2       = r2_q;
  assign R3       = r3_q;
  assign ALUOp    = op_q;
  assign overflow = ovf_q;
  assign zero     = zero_q;
  assign carry    = carry_q;
  assign busy     = busy_q;
  assign dbg_data = rf_q[dbg_addr];

endmodule

// File: doc/operand_issue.md
# operand_issue

Issue stage that sits directly upstream of the pipelined `ALU` and writes its results back. It holds an `NREG`-entry register file and accepts 12-bit instructions over a valid/ready handshake. For each accepted instruction it drives `R2`, `R3` and `ALUOp` into the ALU, then writes the returned result and flags back after a fixed latency. A scoreboard stalls any instruction that touches a register with a write still in flight.

## Interface
- `n`, 32, datapath width; matches `ALU #(n)`.
- `LAT`, 1, ALU latency in cycles, from operands presented to `alu_result` valid; legal range 1..3.
- `NREG`, 8, register count; fixed at 8 because fields are 3 bits.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `instr_valid`  in  1  an instruction is offered.
- `instr_ready`  out  1  the stage can accept the instruction this cycle.
- `instr`  in  12  fields: `[11:9]` op, `[8:6]` rd, `[5:3]` rs, `[2:0]` rt.
- `ld_en`  in  1  host register load strobe.
- `ld_addr`  in  3  register to load.
- `ld_data`  in  n  value to load.
- `R2`  out  n  operand A to the ALU (registered).
- `R3`  out  n  operand B to the ALU (registered).
- `ALUOp`  out  3  ALU opcode (registered).
- `alu_result`  in  n  ALU result.
- `alu_overflow`, `alu_zero`, `alu_carry`  in  1 each  ALU flags.
- `overflow`, `zero`, `carry`  out  1 each  flags from the most recent writeback.
- `busy`  out  1  at least one instruction is in flight.
- `dbg_addr`  in  3  debug read address.
- `dbg_data`  out  n  combinational read of `reg[dbg_addr]`.

## Operation
- Op codes pass through unchanged to the ALU:
  - 000 MOV, 001 NOT, 010 ADD, 011 NOR, 100 SUB, 101 NAND, 110 SLT.
  - 111 is also passed through; its result is written back like any other op.
- Handshake: an instruction is accepted when `instr_valid && instr_ready` at a rising edge.
  - `instr` must be held stable while valid and not ready.
- `instr_ready` is 0 when either condition holds:
  - `ld_en` = 1;
  - `pending[rs]`, `pending[rt]` or `pending[rd]` is set (RAW and WAW hazards).
- `instr_ready` is 1 otherwise; it is combinational.
- On accept:
  - `R2` ← `reg[rs]`, `R3` ← `reg[rt]`, `ALUOp` ← op;
  - `pending[rd]` ← 1;
  - a token {valid, rd} enters a shift line of depth `LAT+1`.
- With no accept, `R2`, `R3` and `ALUOp` hold their values. The ALU keeps computing, but no writeback is scheduled.
- Writeback happens on the edge where a valid token leaves the shift line:
  - `reg[rd]` ← `alu_result`;
  - `overflow`/`zero`/`carry` ← the ALU flags;
  - `pending[rd]` ← 0.
- Non-writeback cycles leave the flags unchanged.
- A register-0 write is an ordinary write; register 0 is not hardwired.
- Host load: `ld_en` writes `reg[ld_addr]` ← `ld_data` at the edge, without checking pending.
  - If a writeback targets the same address on the same edge, the writeback wins.
- `busy` = OR of all token valids.
- The shift line holds at most `LAT+1` tokens. Throughput is one instruction per cycle when operands are independent.

## Timing
- Accept at edge k:
  - operands are visible from k to k+1;
  - the ALU samples them at k+1;
  - writeback occurs at edge k+1+LAT.
- With LAT=1, writeback is at k+2.
- Dependent instructions:
  - `pending` clears at the writeback edge, so a dependent instruction is ready in the following cycle and reads the updated value;
  - dependent spacing is `LAT+2` cycles;
  - there is no bypass path.
- Reset (`rst_n`=0, asynchronous, effective immediately):
  - all registers 0;
  - `R2`, `R3` = 0; `ALUOp` = 000;
  - `pending` = 0; shift line cleared;
  - flags 0; `busy` = 0.
- `instr_ready` during reset follows its combinational rule and evaluates to 1 (unless `ld_en` = 1); nothing is accepted while `rst_n`=0.
- Reset mid-operation discards in-flight tokens; no writeback occurs after release.

## Test plan
- **Load and read back.** Reset, then `ld_en` r1=5, r2=12 → `dbg_data` shows 5 and 12; `instr_ready`=0 during each load cycle.
- **Independent ADD.** Issue ADD r3,r1,r2 with LAT=1 → `R2`=5, `R3`=12, `ALUOp`=010 one cycle after accept; r3=17 and `zero`=0 two edges after accept.
- **RAW stall.** Issue SUB r4,r3,r1 immediately after the ADD → `instr_ready`=0 until the r3 writeback edge; then r4=12 (17−5).
- **Flag capture.** Load r5=r6=32'hFFFFFFFF, issue SUB r7,r5,r6 → r7=0, `zero`=1. Follow with NOT r0,r5 → r0=0, `zero`=1. Flags hold between writebacks.
- **Back-to-back throughput and writeback priority.**
  - Three independent instructions (MOV, NOR, SLT on disjoint registers) → accepted on consecutive cycles; three writebacks on consecutive edges; `busy` drops one cycle after the last.
  - `ld_en` to the same rd as a writeback edge → the writeback value is stored.
- **Reset mid-flight.** Assert `rst_n`=0 one cycle after accepting ADD r3 → r3=0, `busy`=0, `pending` clear; after release the first instruction is accepted at once.
